instr_fetch_aligner: RTL

- Instruction fetch front end that produces the instruction and PC stream consumed by the IF/ID pipeline register.
- Fetches aligned 32-bit words from instruction memory and splits them into 16-bit compressed (RVC) and 32-bit instructions.
- Handles 32-bit instructions that straddle a word boundary.
- Honours the pipeline Stall and Flush/redirect controls.

---
 rtl/instr_fetch_aligner.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_aligner.sv
// Fetch front end: pulls aligned words from instruction memory and carves them
// into 16-bit (RVC) and 32-bit instructions, including ones straddling a word.
module instr_fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [31:0] redirect_PC_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_valid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] PC_o,
  output logic        compress_o,
  output logic        valid_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic        skip_lo_q, skip_lo_d;
  logic [15:0] hold_q, hold_d;
  logic        hold_v_q, hold_v_d;
  logic [31:0] word_q, word_d;
  logic        word_v_q, word_v_d;
  logic        pend_q, pend_d;
  logic        drop_q, drop_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        compress_q, compress_d;
  logic        valid_q, valid_d;

  logic        issue_en, consume, iss, iss_c, req;
  logic [31:0] iss_instr;
  logic        hold_c, lo_c, hi_c;

  assign hold_c = (hold_q[1:0] != 2'b11);
  assign lo_c   = (word_q[1:0] != 2'b11);
  assign hi_c   = (word_q[17:16] != 2'b11);

  always_comb begin
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    skip_lo_d    = skip_lo_q;
    hold_d       = hold_q;
    hold_v_d     = hold_v_q;
    word_d       = word_q;
    word_v_d     = word_v_q;
    pend_d       = pend_q;
    drop_d       = drop_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    compress_d   = compress_q;
    valid_d      = valid_q;
    consume      = 1'b0;
    iss          = 1'b0;
    iss_c        = 1'b0;
    iss_instr    = NOP;
    issue_en     = !Flush && !Stall;

    // Issue rules, first match wins.
    if (issue_en) begin
      if (hold_v_q && hold_c) begin
        iss       = 1'b1;
        iss_c     = 1'b1;
        iss_instr = {16'h0, hold_q};
        hold_v_d  = 1'b0;
      end else if (hold_v_q && word_v_q) begin
        iss       = 1'b1;
        iss_instr = {word_q[15:0], hold_q};
        hold_d    = word_q[31:16];
        consume   = 1'b1;
      end else if (!hold_v_q && word_v_q && skip_lo_q) begin
        skip_lo_d = 1'b0;
        consume   = 1'b1;
        if (hi_c) begin
          iss       = 1'b1;
          iss_c     = 1'b1;
          iss_instr = {16'h0, word_q[31:16]};
        end else begin
          hold_d   = word_q[31:16];
          hold_v_d = 1'b1;
        end
      end else if (!hold_v_q && word_v_q && lo_c) begin
        iss       = 1'b1;
        iss_c     = 1'b1;
        iss_instr = {16'h0, word_q[15:0]};
        hold_d    = word_q[31:16];
        hold_v_d  = 1'b1;
        consume   = 1'b1;
      end else if (!hold_v_q && word_v_q) begin
        iss       = 1'b1;
        iss_instr = word_q;
        consume   = 1'b1;
      end

      pc_out_d = pc_q;
      if (iss) begin
        instr_d    = iss_instr;
        compress_d = iss_c;
        valid_d    = 1'b1;
        pc_d       = pc_q + (iss_c ? 32'd2 : 32'd4);
      end else begin
        instr_d    = NOP;
        compress_d = 1'b0;
        valid_d    = 1'b0;
      end
    end

    req = rst_n && !Flush && !pend_q && (!word_v_q || consume);
    if (req) begin
      fetch_addr_d = fetch_addr_q + 32'd4;
      pend_d       = 1'b1;
    end

    if (consume) word_v_d = 1'b0;

    // Responses land regardless of Stall; a drop marks a pre-redirect fetch.
    if (imem_valid_i && pend_q) begin
      pend_d = 1'b0;
      if (drop_q) begin
        drop_d = 1'b0;
      end else begin
        word_d   = imem_rdata_i;
        word_v_d = 1'b1;
      end
    end

    if (Flush) begin
      pc_d         = {redirect_PC_i[31:1], 1'b0};
      fetch_addr_d = redirect_PC_i & ~32'd3;
      skip_lo_d    = redirect_PC_i[1];
      hold_v_d     = 1'b0;
      word_v_d     = 1'b0;
      drop_d       = pend_q && !imem_valid_i;
      pend_d       = pend_q && !imem_valid_i;
      instr_d      = NOP;
      pc_out_d     = pc_q;
      compress_d   = 1'b0;
      valid_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      fetch_addr_q <= RESET_PC & ~32'd3;
      skip_lo_q    <= RESET_PC[1];
      hold_q       <= 16'h0;
      hold_v_q     <= 1'b0;
      word_q       <= 32'h0;
      word_v_q     <= 1'b0;
      pend_q       <= 1'b0;
      drop_q       <= 1'b0;
      instr_q      <= NOP;
      pc_out_q     <= 32'h0;
      compress_q   <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      skip_lo_q    <= skip_lo_d;
      hold_q       <= hold_d;
      hold_v_q     <= hold_v_d;
      word_q       <= word_d;
      word_v_q     <= word_v_d;
      pend_q       <= pend_d;
      drop_q       <= drop_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      compress_q   <= compress_d;
      valid_q      <= valid_d;
    end
  end

  assign imem_req_o  = req;
  assign imem_addr_o = fetch_addr_q;
  assign instr_o     = instr_q;
  assign PC_o        = pc_out_q;
  assign compress_o  = compress_q;
  assign valid_o     = valid_q;

endmodule
